bitscan_64b: RTL and testbench

//   Serialises a 64-bit set vector into the 6-bit indices of its set bits, one index per beat.

---
 rtl/bitscan_64b.sv | 104 ++++++++++
 tb/tb_bitscan_64b.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitscan_64b.sv
// Bit-scan serialiser: turns a 64-bit set vector into a stream of set-bit indices,
// one index per accepted beat, in ascending or descending order.
module bitscan_64b #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [63:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [5:0]  out_data_o,
    output logic        out_last_o,
    output logic        out_empty_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]  r_state;
    logic [63:0] r_mask;
    logic [5:0]  r_data;
    logic        r_last;
    logic        r_empty;
    logic        r_valid;

    logic        w_accept;
    logic        w_xfer;
    logic [63:0] w_mask_clr;
    logic [5:0]  w_load_idx;
    logic        w_load_last;
    logic [5:0]  w_next_idx;
    logic        w_next_last;

    // Priority encoder; the last match written wins, so loop direction selects the order.
    function automatic logic [5:0] f_first(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        if (LSB_FIRST) begin
            for (int i = 63; i >= 0; i--) begin
                if (v[i]) idx = 6'(i);
            end
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (v[i]) idx = 6'(i);
            end
        end
        return idx;
    endfunction

    // True when at most one bit is set: that beat is the final one for the vector.
    function automatic logic f_at_most_one(input logic [63:0] v);
        return ((v & (v - 64'd1)) == 64'd0);
    endfunction

    assign in_ready_o  = (r_state == ST_IDLE);
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_xfer      = (r_state == ST_SCAN) & r_valid & out_ready_i;

    assign w_load_idx  = f_first(in_data_i);
    assign w_load_last = f_at_most_one(in_data_i);

    // Look-ahead from the mask with the current beat removed keeps one beat per clock.
    assign w_mask_clr  = r_mask & ~(64'd1 << r_data);
    assign w_next_idx  = f_first(w_mask_clr);
    assign w_next_last = f_at_most_one(w_mask_clr);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_empty <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_state <= ST_SCAN;
            r_mask  <= in_data_i;
            r_data  <= w_load_idx;
            r_last  <= w_load_last;
            r_empty <= (in_data_i == 64'd0);
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            if (r_last) begin
                r_state <= ST_IDLE;
                r_mask  <= '0;
                r_last  <= 1'b0;
                r_empty <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                r_mask  <= w_mask_clr;
                r_data  <= w_next_idx;
                r_last  <= w_next_last;
            end
        end
    end

    assign out_data_o  = r_data;
    assign out_last_o  = r_last;
    assign out_empty_o = r_empty;
    assign out_valid_o = r_valid;

endmodule

// File: tb/tb_bitscan_64b.sv
// Bench for bitscan_64b: ascending and descending instances run in lockstep on shared
// inputs and are checked against per-vector index queues built from the set bits.
module tb_bitscan_64b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_l, in_ready_m;
    logic [5:0]  data_l, data_m;
    logic        last_l, last_m;
    logic        empty_l, empty_m;
    logic        valid_l, valid_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bitscan_64b #(.LSB_FIRST(1'b1)) u_lsb (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_l),
        .out_data_o (data_l),
        .out_last_o (last_l),
        .out_empty_o(empty_l),
        .out_valid_o(valid_l),
        .out_ready_i(out_ready)
    );

    bitscan_64b #(.LSB_FIRST(1'b0)) u_msb (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_m),
        .out_data_o (data_m),
        .out_last_o (last_m),
        .out_empty_o(empty_m),
        .out_valid_o(valid_m),
        .out_ready_i(out_ready)
    );

    typedef struct {
        logic [63:0] vec;
        int          first_l;
        int          first_m;
        int          cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one vector and check every beat on both instances against the model queues.
    // mode 0: always ready, 1: ready toggles 1,0,1,0..., 2: random ready.
    task automatic run_vector(input logic [63:0] vec, input int mode, input bit junk,
                              output int first_l, output int first_m, output int nbeats);
        int ql[$];
        int qm[$];
        bit zero;
        bit rdy;
        int guard;
        int k;
        zero = (vec == 64'd0);
        if (zero) begin
            ql.push_back(0);
            qm.push_back(0);
        end else begin
            for (int i = 0; i < 64; i++)  if (vec[i]) ql.push_back(i);
            for (int i = 63; i >= 0; i--) if (vec[i]) qm.push_back(i);
        end
        first_l = ql[0];
        first_m = qm[0];
        nbeats  = 0;

        guard = 0;
        while (!(in_ready_l && in_ready_m) && guard < 20) begin
            tick();
            guard++;
        end
        chk("in_ready_idle", {62'd0, in_ready_l, in_ready_m}, 64'd3);

        in_data   = vec;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};

        k = 0;
        guard = 0;
        while (ql.size() > 0 && guard < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 2 == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = rdy;
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom, $urandom};
            end
            chk("beat_valid", {62'd0, valid_l, valid_m}, 64'd3);
            chk("scan_in_ready", {62'd0, in_ready_l, in_ready_m}, 64'd0);
            chk("beat_idx_lsb", 64'(data_l), 64'(ql[0]));
            chk("beat_idx_msb", 64'(data_m), 64'(qm[0]));
            chk("beat_last", {62'd0, last_l, last_m}, (ql.size() == 1) ? 64'd3 : 64'd0);
            chk("beat_empty", {62'd0, empty_l, empty_m}, zero ? 64'd3 : 64'd0);
            tick();
            k++;
            guard++;
            if (rdy) begin
                void'(ql.pop_front());
                void'(qm.pop_front());
                nbeats++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("drain_done", 64'(ql.size()), 64'd0);
        chk("post_valid", {62'd0, valid_l, valid_m}, 64'd0);
        chk("post_in_ready", {62'd0, in_ready_l, in_ready_m}, 64'd3);
    endtask

    initial begin
        int fl, fm, nb;
        logic [63:0] v;

        tbl[0] = '{64'h8000_0000_0000_0011, 0, 63, 3};
        tbl[1] = '{64'h0, 0, 0, 1};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 63, 64};
        tbl[3] = '{64'h1, 0, 0, 1};
        tbl[4] = '{64'h8000_0000_0000_0000, 63, 63, 1};
        tbl[5] = '{64'hF0, 4, 7, 4};
        tbl[6] = '{64'h5, 0, 2, 2};
        tbl[7] = '{64'h0000_0001_0000_0000, 32, 32, 1};

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_valid", {62'd0, valid_l, valid_m}, 64'd0);
        chk("rst_last", {62'd0, last_l, last_m}, 64'd0);
        chk("rst_empty", {62'd0, empty_l, empty_m}, 64'd0);
        chk("rst_data", {52'd0, data_l, data_m}, 64'd0);
        chk("rst_in_ready", {62'd0, in_ready_l, in_ready_m}, 64'd3);

        // T1/T2: exact beat timing for both orders
        in_data   = 64'h8000_0000_0000_0011;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_b0", {50'd0, valid_l, last_l, data_l, data_m}, {50'd0, 1'b1, 1'b0, 6'd0, 6'd63});
        tick();
        chk("t1_b1", {50'd0, valid_l, last_l, data_l, data_m}, {50'd0, 1'b1, 1'b0, 6'd4, 6'd4});
        tick();
        chk("t1_b2", {50'd0, valid_l, last_l, data_l, data_m}, {50'd0, 1'b1, 1'b1, 6'd63, 6'd0});
        chk("t2_last_msb", {63'd0, last_m}, 64'd1);
        tick();
        chk("t1_gap", {62'd0, valid_l, valid_m}, 64'd0);
        chk("t1_ready", {62'd0, in_ready_l, in_ready_m}, 64'd3);
        out_ready = 1'b0;

        // Table vectors: first index and beat count per order
        foreach (tbl[i]) begin
            run_vector(tbl[i].vec, 0, 1'b0, fl, fm, nb);
            chk("tbl_first_lsb", 64'(fl), 64'(tbl[i].first_l));
            chk("tbl_first_msb", 64'(fm), 64'(tbl[i].first_m));
            chk("tbl_count", 64'(nb), 64'(tbl[i].cnt));
            $display("vector %016h: beats=%0d first_lsb=%0d first_msb=%0d", tbl[i].vec, nb, fl, fm);
        end

        // T4: all ones with toggling ready; stalls must hold the beat
        run_vector(64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, fl, fm, nb);
        chk("t4_count", 64'(nb), 64'd64);

        // T6: one-hot replay of 64'h5 as the downstream decoder would see it
        in_data   = 64'h5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t6_onehot0", 64'd1 << data_l, 64'h1);
        tick();
        chk("t6_onehot1", 64'd1 << data_l, 64'h4);
        tick();
        out_ready = 1'b0;

        // T5: reset after beats 4,5 transferred
        in_data   = 64'hF0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t5_pre_idx", 64'(data_l), 64'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {62'd0, valid_l, valid_m}, 64'd0);
        chk("t5_rst_data", {52'd0, data_l, data_m}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t5_in_ready", {62'd0, in_ready_l, in_ready_m}, 64'd3);
        for (int c = 0; c < 5; c++) begin
            chk("t5_no_beats", {62'd0, valid_l, valid_m}, 64'd0);
            tick();
        end
        out_ready = 1'b0;

        // Random vectors, random back-pressure, junk input traffic during scan
        for (int r = 0; r < 40; r++) begin
            v = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       v = v & {$urandom, $urandom} & {$urandom, $urandom};
                1:       v = 64'd1 << $urandom_range(0, 63);
                2:       v = v | {$urandom, $urandom};
                default: v = v & {$urandom, $urandom};
            endcase
            run_vector(v, 2, 1'b1, fl, fm, nb);
            chk("rand_count", 64'(nb), (v == 64'd0) ? 64'd1 : 64'($countones(v)));
            $display("random vector %016h: beats=%0d", v, nb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
